dmem_ctrl: RTL

Sequencing and arbitration controller for the byte-addressed, big-endian data memory (256 bytes; byte/halfword/word access; combinational read, write while enabled). It shares the single memory port between two requesters: port 0 is the pipeline MEM stage and port 1 is the test loader/debug port. It uses a round-robin arbiter and a req/ack handshake. It also checks alignment and range, suppresses faulting writes, and optionally sign-extends byte and halfword loads.

---
 rtl/dmem_ctrl_pkg.sv | 36 +++
 rtl/dmem_ctrl_if.sv | 44 ++++
 rtl/dmem_ctrl_rr_arb2.sv | 25 ++
 rtl/dmem_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl shared types
// sizes, states, request bundle
package dmem_pkg;

  localparam int DMEM_DEPTH = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl bus bundle
// two requester ports plus memory port
interface dmem_if;

  logic        req0, req1;
  logic        rw0, rw1;
  logic [1:0]  size0, size1;
  logic        sext0, sext1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        busy;
  logic [31:0] mem_a;
  logic [31:0] mem_di;
  logic [1:0]  mem_size;
  logic        mem_rw;
  logic        mem_e;
  logic [31:0] mem_do;

  modport master (
    output req0, req1, rw0, rw1,
    output size0, size1, sext0, sext1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1,
    input  rdata0, rdata1, busy,
    input  mem_a, mem_di, mem_size,
    input  mem_rw, mem_e,
    output mem_do
  );

  modport slave (
    input  req0, req1, rw0, rw1,
    input  size0, size1, sext0, sext1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1,
    output rdata0, rdata1, busy,
    output mem_a, mem_di, mem_size,
    output mem_rw, mem_e,
    input  mem_do
  );

endinterface

// File: rtl/dmem_ctrl_rr_arb2.sv
// two-way round-robin arbiter
// pointer moves only on the upd strobe
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       win
);

  logic last;

  // on a tie the port not granted last wins
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
  end

  // remember the most recent grant
  always_ff @(posedge clk) begin
    if (reset) last <= 1'b1;
    else if (upd) last <= win;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// data memory sequencer and arbiter
// IDLE -> ACCESS -> RESP per transaction
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  state_e      state;
  req_t        cur;
  req_t        in0, in1;
  logic        id;
  logic        win, upd;
  logic        fault, acc, wr_ok;
  logic [32:0] lim;
  logic [31:0] rfmt, rd_val;
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  assign in0 = '{rw: bus.rw0,
                 size: bus.size0,
                 sext: bus.sext0,
                 addr: bus.addr0,
                 wdata: bus.wdata0};
  assign in1 = '{rw: bus.rw1,
                 size: bus.size1,
                 sext: bus.sext1,
                 addr: bus.addr1,
                 wdata: bus.wdata1};

  assign upd = (state == IDLE)
             && (bus.req0 || bus.req1);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1, bus.req0}),
    .upd   (upd),
    .win   (win)
  );

  // 33-bit end address so top-of-space
  // requests cannot wrap back in range
  assign lim = {1'b0, cur.addr}
             + 33'(size_bytes(cur.size));

  assign fault =
      (cur.size == SZ_ILL)
   || (cur.size == SZ_HALF && cur.addr[0])
   || (cur.size == SZ_WORD
       && cur.addr[1:0] != 2'b00)
   || (lim > 33'(DEPTH));

  assign acc   = (state == ACCESS);
  assign wr_ok = acc && cur.rw && !fault;

  assign bus.mem_a    = acc ? cur.addr : '0;
  assign bus.mem_di   = acc ? cur.wdata : '0;
  assign bus.mem_size = acc ? cur.size : '0;
  assign bus.mem_rw   = wr_ok;
  assign bus.mem_e    = wr_ok && !reset;

  // sign-extend narrow loads on request
  always_comb begin
    rfmt = bus.mem_do;
    unique case (1'b1)
      cur.sext && cur.size == SZ_BYTE:
        rfmt = {{24{bus.mem_do[7]}},
                bus.mem_do[7:0]};
      cur.sext && cur.size == SZ_HALF:
        rfmt = {{16{bus.mem_do[15]}},
                bus.mem_do[15:0]};
      default: ;
    endcase
  end

  assign rd_val = (!cur.rw && !fault)
                ? rfmt : '0;

  // sequencer with registered responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur      <= '0;
      id       <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (upd) begin
            id    <= win;
            cur   <= win ? in1 : in0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          ack0_q   <= !id;
          ack1_q   <= id;
          err0_q   <= !id && fault;
          err1_q   <= id && fault;
          rdata0_q <= id ? '0 : rd_val;
          rdata1_q <= id ? rd_val : '0;
          state    <= RESP;
        end
        RESP: begin
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          err0_q   <= 1'b0;
          err1_q   <= 1'b0;
          rdata0_q <= '0;
          rdata1_q <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = (state != IDLE);

endmodule
